// File: rtl/dct_coef_accumulator.sv
// dct_coef_accumulator
// Computes one 2-D DCT coefficient of an 8x8 block. It walks all 64 pixel
// positions, multiplies each level-shifted pixel by the cosine term that the
// external LUT returns for the same (n1,n2), and accumulates the products.
// The scaled, saturated result is then offered on a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle request, honoured only in IDLE
//   busy                high from the accepted start until coef is taken
//   pix_rd_en/pix_addr  pixel buffer read, {row,col} row-major
//   pix_data            pixel, one cycle after the read
//   n1/n2               LUT indices, aligned with pix_data
//   cos_term            signed LUT output (COS_FRAC fractional bits)
//   coef/coef_valid     result and its valid flag
//   coef_ready          downstream accept
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | issuing addresses 0..63, accumulating returned data
// DRAIN | no read issued, accumulating the 64th term, producing coef
// HOLD  | coef_valid high, waiting for coef_ready
module dct_coef_accumulator #(
    parameter int PIX_W       = 8,
    parameter int ACC_W       = 32,
    parameter int COS_FRAC    = 8,
    parameter int LEVEL_SHIFT = 128,
    parameter int COEF_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     pix_rd_en,
    output logic [5:0]               pix_addr,
    input  logic [PIX_W-1:0]         pix_data,
    output logic [2:0]               n1,
    output logic [2:0]               n2,
    input  logic signed [31:0]       cos_term,
    output logic signed [COEF_W-1:0] coef,
    output logic                     coef_valid,
    input  logic                     coef_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    localparam logic signed [ACC_W-1:0] COEF_MAX = ACC_W'(2**(COEF_W-1) - 1);
    localparam logic signed [ACC_W-1:0] COEF_MIN = ACC_W'(-(2**(COEF_W-1)));

    state_t                   state;
    logic                     rd_d;     // pix_data holds a requested pixel this cycle
    logic signed [ACC_W-1:0]  acc;

    logic signed [PIX_W:0]    pix_s;
    logic signed [ACC_W-1:0]  pix_ext;
    logic signed [ACC_W-1:0]  cos_ext;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_shr;
    logic signed [COEF_W-1:0] coef_sat;

    // Zero-extend the pixel by one bit so the level shift yields a signed value.
    assign pix_s   = $signed({1'b0, pix_data}) - $signed((PIX_W+1)'(LEVEL_SHIFT));
    assign pix_ext = ACC_W'(pix_s);
    assign cos_ext = ACC_W'(cos_term);
    assign term    = pix_ext * cos_ext;
    assign acc_sum = acc + term;
    assign acc_shr = acc_sum >>> COS_FRAC;

    always_comb begin
        coef_sat = COEF_W'(acc_shr);
        if (acc_shr > COEF_MAX) begin
            coef_sat = COEF_W'(COEF_MAX);
        end else if (acc_shr < COEF_MIN) begin
            coef_sat = COEF_W'(COEF_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            pix_rd_en  <= 1'b0;
            pix_addr   <= '0;
            n1         <= '0;
            n2         <= '0;
            rd_d       <= 1'b0;
            acc        <= '0;
            coef       <= '0;
            coef_valid <= 1'b0;
        end else begin
            // LUT indices trail the address by one cycle, matching pixel latency.
            n1   <= pix_addr[5:3];
            n2   <= pix_addr[2:0];
            rd_d <= pix_rd_en;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        pix_rd_en <= 1'b1;
                        pix_addr  <= '0;
                        acc       <= '0;
                    end
                end
                RUN: begin
                    if (rd_d) begin
                        acc <= acc_sum;
                    end
                    if (pix_addr == 6'd63) begin
                        pix_rd_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        pix_addr <= pix_addr + 6'd1;
                    end
                end
                DRAIN: begin
                    acc        <= acc_sum;
                    coef       <= coef_sat;
                    coef_valid <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (coef_ready) begin
                        coef_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_coef_accumulator.sv
// Directed bench for dct_coef_accumulator: pixel buffer model with one-cycle
// read latency and a k1=3/k2=4 cosine LUT (or a constant for saturation).
module tb_dct_coef_accumulator;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               busy;
    logic               pix_rd_en;
    logic [5:0]         pix_addr;
    logic [7:0]         pix_data;
    logic [2:0]         n1;
    logic [2:0]         n2;
    logic signed [31:0] cos_term;
    logic signed [15:0] coef;
    logic               coef_valid;
    logic               coef_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0] pix_mem [64];
    int         lut [64];
    logic       lut_const;

    dct_coef_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .pix_rd_en  (pix_rd_en),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .n1         (n1),
        .n2         (n2),
        .cos_term   (cos_term),
        .coef       (coef),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pix_rd_en) pix_data <= pix_mem[pix_addr];
        else           pix_data <= 8'd0;
    end

    always_comb begin
        if (lut_const) cos_term = 32'sd2000;
        else           cos_term = 32'(lut[{n1, n2}]);
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_pixels(input logic [7:0] val);
        for (int i = 0; i < 64; i++) pix_mem[i] = val;
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic run_coef(input string tag, input int exp_coef, input int hold_cyc);
        int n, reads, bad_addr, bad_hold;
        logic signed [15:0] held;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val({tag, "_busy"}, int'(busy), 1);
        n = 1; reads = 0; bad_addr = 0;
        while (!coef_valid && n < 200) begin
            if (pix_rd_en) begin
                if (int'(pix_addr) != reads) bad_addr++;
                reads++;
            end
            start = (n == 20);      // start during RUN must be ignored
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check_val({tag, "_latency"}, n, 66);
        check_val({tag, "_reads"}, reads, 64);
        check_val({tag, "_addr_seq"}, bad_addr, 0);
        check_val({tag, "_coef"}, int'(coef), exp_coef);
        held = coef; bad_hold = 0;
        for (int i = 0; i < hold_cyc; i++) begin
            start = (i == 3);
            @(posedge clk); #1;
            start = 1'b0;
            if (coef !== held || !coef_valid || pix_rd_en || !busy) bad_hold++;
        end
        if (hold_cyc > 0) check_val({tag, "_hold_stable"}, bad_hold, 0);
        coef_ready = 1'b1;
        start = (hold_cyc > 0);     // coincident start in HOLD is dropped
        @(posedge clk); #1;
        coef_ready = 1'b0;
        start = 1'b0;
        check_val({tag, "_valid_drop"}, int'(coef_valid), 0);
        check_val({tag, "_busy_drop"}, int'(busy), 0);
        check_val({tag, "_coef_kept"}, int'(coef), exp_coef);
        @(posedge clk); #1;
        check_val({tag, "_idle_after"}, int'(pix_rd_en | busy), 0);
    endtask

    initial begin
        int n;
        real pi;
        pi = 3.14159265358979;
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                lut[a*8+b] = $rtoi($cos((2*a+1)*3*pi/16.0) * $cos((2*b+1)*4*pi/16.0) * 256.0);

        rst_n = 1'b0; start = 1'b0; coef_ready = 1'b0; lut_const = 1'b0;
        fill_pixels(8'd128);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_rd_en", int'(pix_rd_en), 0);
        check_val("rst_valid", int'(coef_valid), 0);
        check_val("rst_coef", int'(coef), 0);
        check_val("rst_addr", int'(pix_addr), 0);
        check_val("rst_n1n2", int'({n1, n2}), 0);
        check_val("lut_00", lut[0], 150);
        check_val("lut_10", lut[8], -35);
        rst_n = 1'b1;
        @(posedge clk); #1;

        fill_pixels(8'd128);
        run_coef("flat", 0, 0);

        fill_pixels(8'd128); pix_mem[0] = 8'd255;
        run_coef("p00_255_bp", 74, 10);

        fill_pixels(8'd128); pix_mem[8] = 8'd0;
        run_coef("p10_0", 17, 0);

        fill_pixels(8'd128); pix_mem[0] = 8'd0;
        run_coef("p00_0", -75, 0);

        fill_pixels(8'd128); pix_mem[1] = 8'd255;
        run_coef("p01_floor", -75, 0);

        lut_const = 1'b1;
        fill_pixels(8'd255);
        run_coef("sat_pos", 32767, 0);
        fill_pixels(8'd0);
        run_coef("sat_neg", -32768, 0);
        lut_const = 1'b0;

        fill_pixels(8'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (pix_addr != 6'd30 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("mid_reach30", int'(pix_addr), 30);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("mid_rst_busy", int'(busy), 0);
        check_val("mid_rst_rd_en", int'(pix_rd_en), 0);
        check_val("mid_rst_valid", int'(coef_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_pixels(8'd128); pix_mem[0] = 8'd255;
        run_coef("after_rst", 74, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dct_coef_accumulator.md
Name: dct_coef_accumulator

Overview:
- Computes one 2-D DCT coefficient for an 8x8 pixel block.
- Walks all 64 (n1,n2) positions, reads each pixel from the block buffer, and drives the same (n1,n2) to a per-coefficient cosine LUT (combinational, 32-bit signed, 8 fractional bits).
- Multiply-accumulates level-shifted pixel x cos_term, then emits the scaled coefficient over a valid/ready handshake to the quantiser stage.
- Sits directly downstream of a k1/k2 cosine LUT instance; one instance per LUT.

Parameters:
- PIX_W, 8, unsigned pixel width
- ACC_W, 32, signed accumulator and product width
- COS_FRAC, 8, fractional bits of cos_term; removed by arithmetic right shift at output
- LEVEL_SHIFT, 128, subtracted from each pixel before multiply
- COEF_W, 16, signed output coefficient width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to compute a coefficient; sampled only in IDLE
- busy  out  1  high from the accepted start until the coefficient handshake completes
- pix_rd_en  out  1  pixel buffer read enable
- pix_addr  out  6  {row n1, col n2}, row-major
- pix_data  in  PIX_W  pixel; valid exactly 1 cycle after pix_rd_en/pix_addr
- n1  out  3  LUT row index, aligned with pix_data
- n2  out  3  LUT column index, aligned with pix_data
- cos_term  in  32  signed LUT output, combinational from n1/n2
- coef  out  COEF_W  signed result
- coef_valid  out  1  coef valid
- coef_ready  in  1  downstream accepts coef when high with coef_valid

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n low at a rising edge), including mid-operation:
  - state goes to IDLE.
  - busy, pix_rd_en, coef_valid = 0; pix_addr, n1, n2 = 0; accumulator = 0; coef = 0.
  - Any in-flight computation is discarded.
- States: IDLE, RUN, DRAIN, HOLD.
- IDLE:
  - start=1 moves to RUN, clears the accumulator and the address counter, and asserts busy.
  - start=0 stays in IDLE.
- RUN:
  - pix_rd_en=1; pix_addr = counter 0..63, incremented every cycle.
  - After issuing address 63, go to DRAIN.
- Index alignment:
  - n1/n2 are pix_addr[5:3]/pix_addr[2:0] registered one cycle, so the LUT indexes the pixel currently on pix_data.
- Datapath (every cycle that data from a read is on pix_data):
  - term = (signed(pix_data) - LEVEL_SHIFT) * cos_term.
  - Pixel is extended to PIX_W+1 signed before the subtract; the product is truncated to ACC_W.
  - acc += term, wrapping at ACC_W (no saturation).
- DRAIN (1 cycle):
  - pix_rd_en=0; accumulate the 64th term.
  - Go to HOLD with coef = saturate_COEF_W(acc_final >>> COS_FRAC), i.e. arithmetic shift, floor rounding, clamped to [-2^(COEF_W-1), 2^(COEF_W-1)-1].
  - coef_valid=1.
- HOLD:
  - coef and coef_valid stay stable until coef_ready=1.
  - On that edge: coef_valid=0, busy=0, go to IDLE; coef keeps its value.
- Latency:
  - start accepted at edge E0; addresses 0..63 presented in cycles 1..64; data arrives in cycles 2..65.
  - coef_valid is high from cycle 66; minimum start-to-start spacing is 67 cycles.
- start while busy (RUN/DRAIN/HOLD) is ignored, with no queuing.
- start and coef_ready in the same HOLD cycle: the handshake completes and that start is ignored; a new start is required in IDLE.
- coef_ready while coef_valid=0 has no effect.

Test Plan:
- All 64 pixels = 128, LUT k1=3/k2=4 -> every term 0; coef = 0, coef_valid at cycle 66 after start, busy low the cycle after coef_ready.
- Pixel(0,0)=255, others 128 -> acc = 127*150 = 19050; coef = 74.
- Pixel(1,0)=0, others 128 -> acc = (-128)*(-35) = 4480; coef = 17.
- Pixel(0,0)=0, others 128 -> acc = -19200; coef = -75. Checks arithmetic shift and sign.
- Back-pressure: coef_ready held low 10 cycles after coef_valid, with start pulsed during HOLD -> coef stable, no new pix_rd_en. Then ready=1 -> coef_valid drops next edge; a fresh start then runs all 64 addresses.
- Reset mid-run: rst_n low at pix_addr=30 -> next cycle busy=0, pix_rd_en=0, coef_valid=0. A following start with pixel(0,0)=255 yields coef=74, proving the accumulator was cleared.
